aes_op_ctrl: RTL and testbench

Host-side initiator for the AES round-sequencing FSM's start/round/done protocol.
- Upstream: accepts one job (mode, direction, key, data) on a valid/ready handshake.
- Core side: holds all core operands stable, issues a single-cycle start, and tracks the core's round counter in lockstep.
- On done: captures the result and presents it downstream on a valid/ready handshake with an error code.
- Sits between the bus/DMA front-end and the AES core plus datapath.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_seq_monitor.sv | 38 +++
 rtl/aes_op_ctrl.sv | 152 +++++++++++++++
 tb/tb_aes_op_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES operation controller and its sequence monitor.
package aes_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned ERR_W   = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_AES128  = 2'b00,
    MODE_AES192  = 2'b01,
    MODE_AES256  = 2'b10,
    MODE_ILLEGAL = 2'b11
  } aes_mode_e;

  localparam logic [ERR_W-1:0] ERR_OK   = 2'b00;
  localparam logic [ERR_W-1:0] ERR_MODE = 2'b01;
  localparam logic [ERR_W-1:0] ERR_SEQ  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESP   = 2'd3
  } ctrl_state_e;

  // Last round number for a key size; the illegal mode never reaches the core.
  function automatic logic [ROUND_W-1:0] final_round(input aes_mode_e mode);
    case (mode)
      MODE_AES128: final_round = 4'd10;
      MODE_AES192: final_round = 4'd12;
      default:     final_round = 4'd14;
    endcase
  endfunction

endpackage

// File: rtl/aes_seq_monitor.sv
// Round counter plus lockstep comparison against the core's round/done outputs.
// hit_final and seq_err are combinational and only meaningful while the core runs.
module aes_seq_monitor
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic [MODE_W-1:0]  mode,
  input  logic [ROUND_W-1:0] core_round,
  input  logic               core_done,
  output logic               hit_final,
  output logic               seq_err
);

  logic [ROUND_W-1:0] cnt;
  logic [ROUND_W-1:0] last_round;
  logic               at_final;

  // Expected round: zero while launching, then one step per running cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + ROUND_W'(1);
    end
  end

  // Round must track cnt and done must coincide exactly with the final round.
  always_comb begin
    last_round = final_round(aes_mode_e'(mode));
    at_final   = (cnt == last_round);
    hit_final  = at_final && core_done && (core_round == cnt);
    seq_err    = (core_round != cnt) || (core_done != at_final);
  end

endmodule

// File: rtl/aes_op_ctrl.sv
// Host-side initiator for the AES core: accepts a job, launches and shadows the
// core round by round, and returns the result or an error code downstream.
module aes_op_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned KEY_W  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic              in_enc_dec,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [DATA_W-1:0] in_data,
  output logic              core_start,
  output logic [1:0]        core_mode,
  output logic              core_enc_dec,
  output logic [KEY_W-1:0]  core_key,
  output logic [DATA_W-1:0] core_data,
  input  logic [3:0]        core_round,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              core_abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err
);

  ctrl_state_e       state, state_next;
  logic              accept;
  logic              load;
  logic              start_next;
  logic              abort_next;
  logic              valid_next;
  logic              ready_next;
  logic [DATA_W-1:0] data_next;
  logic [ERR_W-1:0]  err_next;
  logic              mon_clear;
  logic              mon_en;
  logic              hit_final;
  logic              seq_err;

  assign accept    = (state == ST_IDLE) && in_valid && in_ready;
  assign mon_clear = (state == ST_IDLE);
  assign mon_en    = (state == ST_LAUNCH) || (state == ST_RUN);

  aes_seq_monitor u_mon (
    .clk        (clk),
    .reset      (reset),
    .clear      (mon_clear),
    .en         (mon_en),
    .mode       (core_mode),
    .core_round (core_round),
    .core_done  (core_done),
    .hit_final  (hit_final),
    .seq_err    (seq_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    start_next = 1'b0;
    abort_next = 1'b0;
    valid_next = out_valid;
    data_next  = out_data;
    err_next   = out_err;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (aes_mode_e'(in_mode) == MODE_ILLEGAL) begin
            state_next = ST_RESP;
            valid_next = 1'b1;
            data_next  = '0;
            err_next   = ERR_MODE;
          end else begin
            state_next = ST_LAUNCH;
            start_next = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (seq_err) begin
          state_next = ST_RESP;
          abort_next = 1'b1;
          valid_next = 1'b1;
          data_next  = '0;
          err_next   = ERR_SEQ;
        end else if (hit_final) begin
          state_next = ST_RESP;
          valid_next = 1'b1;
          data_next  = core_result;
          err_next   = ERR_OK;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    ready_next = (state_next == ST_IDLE);
  end

  // Output and operand registers; operands stay put from accept to the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready     <= 1'b0;
      core_start   <= 1'b0;
      core_abort   <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err      <= '0;
      core_mode    <= '0;
      core_enc_dec <= 1'b0;
      core_key     <= '0;
      core_data    <= '0;
    end else begin
      in_ready   <= ready_next;
      core_start <= start_next;
      core_abort <= abort_next;
      out_valid  <= valid_next;
      out_data   <= data_next;
      out_err    <= err_next;
      if (load) begin
        core_mode    <= in_mode;
        core_enc_dec <= in_enc_dec;
        core_key     <= in_key;
        core_data    <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_aes_op_ctrl.sv
// Bench for aes_op_ctrl: behavioural AES core sequencer with fault injection,
// a response scoreboard, and directed jobs with hand-derived timing.
module tb_aes_op_ctrl;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEY_W  = 256;

  localparam logic [127:0] RES128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RES192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] RES256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        in_mode = 2'b00;
  logic              in_enc_dec = 1'b0;
  logic [KEY_W-1:0]  in_key = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              core_start;
  logic [1:0]        core_mode;
  logic              core_enc_dec;
  logic [KEY_W-1:0]  core_key;
  logic [DATA_W-1:0] core_data;
  logic [3:0]        core_round;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic              core_abort;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_err;

  aes_op_ctrl #(.DATA_W(DATA_W), .KEY_W(KEY_W)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_enc_dec   (in_enc_dec),
    .in_key       (in_key),
    .in_data      (in_data),
    .core_start   (core_start),
    .core_mode    (core_mode),
    .core_enc_dec (core_enc_dec),
    .core_key     (core_key),
    .core_data    (core_data),
    .core_round   (core_round),
    .core_done    (core_done),
    .core_result  (core_result),
    .core_abort   (core_abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: rounds 1..N after start, done on N; reset by reset or abort.
  logic       fault_early = 1'b0;
  logic       fault_skip  = 1'b0;
  logic       mdl_active;
  logic [3:0] mdl_round;
  logic [3:0] mdl_n;

  always_comb begin
    case (core_mode)
      2'b00:   mdl_n = 4'd10;
      2'b01:   mdl_n = 4'd12;
      default: mdl_n = 4'd14;
    endcase
  end

  always @(posedge clk) begin
    if (reset || core_abort) begin
      mdl_active <= 1'b0;
      mdl_round  <= 4'd0;
    end else if (core_start) begin
      mdl_active <= 1'b1;
      mdl_round  <= 4'd1;
    end else if (mdl_active) begin
      if (mdl_round == mdl_n) begin
        mdl_active <= 1'b0;
        mdl_round  <= 4'd0;
      end else begin
        mdl_round <= mdl_round + 4'd1;
      end
    end
  end

  always_comb begin
    core_round = (fault_skip && mdl_round == 4'd5) ? 4'd6 : mdl_round;
    core_done  = mdl_active && ((mdl_round == mdl_n) || (fault_early && mdl_round == 4'd9));
    case (core_mode)
      2'b00:   core_result = core_done ? RES128 : '0;
      2'b01:   core_result = core_done ? RES192 : '0;
      default: core_result = core_done ? RES256 : '0;
    endcase
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct packed {
    logic [127:0] data;
    logic [1:0]   err;
  } exp_t;

  exp_t sb[$];

  int start_cnt = 0;
  int abort_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [1:0]   prev_err;

  // Monitor: scoreboard compare on each response handshake, hold check while stalled.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (core_start) start_cnt++;
      if (core_abort) abort_cnt++;
      if (prev_stall) begin
        chk("stall_valid", 256'(out_valid), 256'(1));
        chk("stall_data", 256'(out_data), 256'(prev_data));
        chk("stall_err", 256'(out_err), 256'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 256'(out_valid), 256'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_data", 256'(out_data), 256'(e.data));
          chk("resp_err", 256'(out_err), 256'(e.err));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_err   = out_err;
    end
  end

  int acc_cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    chk("in_ready_wait", 256'(in_ready), 256'(1));
  endtask

  // Offer one job, optionally push its expected response, and check the launch cycle.
  task automatic send(input logic [1:0] m, input logic [255:0] k, input logic [127:0] d,
                      input logic push, input logic [127:0] ed, input logic [1:0] ee);
    wait_ready();
    in_valid   = 1'b1;
    in_mode    = m;
    in_enc_dec = m[0];
    in_key     = k;
    in_data    = d;
    acc_cyc    = cyc;
    if (push) sb.push_back({ed, ee});
    step();
    in_valid = 1'b0;
    in_key   = ~k;
    in_data  = ~d;
    in_mode  = ~m;
    chk("start_pulse", 256'(core_start), 256'(m != 2'b11));
    chk("in_ready_busy", 256'(in_ready), 256'(0));
    if (m != 2'b11) begin
      chk("held_key", core_key, k);
      chk("held_data", 256'(core_data), 256'(d));
      chk("held_mode", 256'(core_mode), 256'(m));
    end
  endtask

  task automatic wait_valid(input int exp_lat);
    int n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
    chk("latency", 256'(cyc - acc_cyc), 256'(exp_lat));
  endtask

  task automatic stall_then_release();
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 256'(in_ready), 256'(0));
      step();
    end
    out_ready = 1'b1;
    step();
    chk("post_hs_valid", 256'(out_valid), 256'(0));
    chk("post_hs_ready", 256'(in_ready), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int a0;

    // Reset values.
    step();
    step();
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_start", 256'(core_start), 256'(0));
    chk("rst_abort", 256'(core_abort), 256'(0));
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_data", 256'(out_data), 256'(0));
    chk("rst_err", 256'(out_err), 256'(0));
    chk("rst_key", core_key, 256'(0));
    reset = 1'b0;
    chk("rst_rel_ready0", 256'(in_ready), 256'(0));
    step();
    chk("rst_rel_ready1", 256'(in_ready), 256'(1));

    // AES128 with out_ready high.
    out_ready = 1'b1;
    send(2'b00, K128, PT, 1'b1, RES128, 2'b00);
    wait_valid(12);
    step();

    // AES192 then AES256 back to back with a stalled consumer.
    out_ready = 1'b0;
    send(2'b01, K192, PT, 1'b1, RES192, 2'b00);
    wait_valid(14);
    stall_then_release();
    out_ready = 1'b0;
    send(2'b10, K256, PT, 1'b1, RES256, 2'b00);
    wait_valid(16);
    stall_then_release();

    // Illegal mode: immediate error, core untouched.
    s0 = start_cnt;
    send(2'b11, K256, PT, 1'b1, 128'h0, 2'b01);
    wait_valid(1);
    step();
    chk("illegal_no_start", 256'(start_cnt), 256'(s0));

    // Early done at round 9 in AES128.
    fault_early = 1'b1;
    a0 = abort_cnt;
    send(2'b00, K128, PT, 1'b1, 128'h0, 2'b10);
    wait_valid(11);
    chk("early_abort_pulse", 256'(core_abort), 256'(1));
    step();
    step();
    chk("early_abort_once", 256'(abort_cnt), 256'(a0 + 1));
    fault_early = 1'b0;
    send(2'b00, K128, PT, 1'b1, RES128, 2'b00);
    wait_valid(12);
    step();

    // Skipped round 5 in AES256.
    fault_skip = 1'b1;
    a0 = abort_cnt;
    send(2'b10, K256, PT, 1'b1, 128'h0, 2'b10);
    wait_valid(7);
    chk("skip_abort_pulse", 256'(core_abort), 256'(1));
    for (int i = 0; i < 4; i++) step();
    chk("skip_abort_once", 256'(abort_cnt), 256'(a0 + 1));
    fault_skip = 1'b0;

    // Reset in the middle of a job: dropped, no response.
    a0 = abort_cnt;
    send(2'b00, K128, PT, 1'b0, 128'h0, 2'b00);
    for (int i = 0; i < 7; i++) step();
    chk("mid_round7", 256'(core_round), 256'(7));
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_mid_start", 256'(core_start), 256'(0));
      chk("rst_mid_valid", 256'(out_valid), 256'(0));
      chk("rst_mid_ready", 256'(in_ready), 256'(0));
    end
    chk("rst_mid_key", core_key, 256'(0));
    reset = 1'b0;
    chk("rst_mid_rel0", 256'(in_ready), 256'(0));
    step();
    chk("rst_mid_rel1", 256'(in_ready), 256'(1));
    for (int i = 0; i < 20; i++) step();
    chk("rst_mid_no_abort", 256'(abort_cnt), 256'(a0));

    // Everything expected must have been seen.
    begin
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
        step();
        n++;
      end
    end
    chk("sb_drained", 256'(sb.size()), 256'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
